reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Integer register file with a write-back port, two combinational read ports, and a busy-bit scoreboard for RAW/WAW hazard detection. Writes come from the write-back stage (`wr_en`, `rd`, `rd_data`). Reads and issue tracking serve the decode/issue stage. The block drives `stall` so an instruction is held until its source and destination registers are safe.

## Interface
Parameters:
- `XLEN`, 32, data width
- `AW`, 5, register index width (2^AW registers)

Ports:
- `clk`  in  1  system clock; the only clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `wr_en`  in  1  write-back write enable
- `wr_rd`  in  AW  write-back destination index
- `wr_data`  in  XLEN  write-back data
- `rs1_addr`, `rs2_addr`  in  AW  read indices
- `rs1_data`, `rs2_data`  out  XLEN  read data
- `issue_valid`  in  1  decode presents an instruction
- `rs1_used`, `rs2_used`  in  1  instruction reads rs1 / rs2
- `issue_wr`  in  1  instruction will write a register
- `issue_rd`  in  AW  destination index of the issuing instruction
- `stall`  out  1  hold the issuing instruction this cycle
- `busy_vec`  out  2^AW  scoreboard bits, for debug

## Operation
- **x0:**
  - Reads of index 0 return 0.
  - Writes to index 0 are ignored.
  - `busy[0]` is never set.
- **Write:** at posedge, if `wr_en` and `wr_rd != 0`, then `regs[wr_rd] <= wr_data`.
- **Read (combinational):**
  - If `wr_en && wr_rd == rsX_addr && rsX_addr != 0`, `rsX_data = wr_data` (write-through bypass).
  - Otherwise `rsX_data = regs[rsX_addr]`.
- **Clearing this cycle:** `clr(i) = wr_en && wr_rd == i`.
- **Effective busy:** `eff_busy(i) = busy[i] && !clr(i)`. A register being written back this cycle is not a hazard, because the bypass supplies its data.
- **Stall** is the AND of `issue_valid` with the OR of these three terms:
  - `rs1_used && eff_busy(rs1_addr)` (RAW on rs1)
  - `rs2_used && eff_busy(rs2_addr)` (RAW on rs2)
  - `issue_wr && eff_busy(issue_rd)` (WAW)
- **Accept:** `accept = issue_valid && !stall`.
- **Busy update at posedge, for each i:**
  - Set if `accept && issue_wr && issue_rd == i && i != 0`.
  - Else clear if `clr(i)`.
  - Else hold.
  - Set wins over clear for the same index in the same cycle. The newer producer owns the register.
- **Write-back without busy:** a write to an index whose busy bit is clear still updates `regs`. The scoreboard is unaffected.

## Timing
- **Reset (asynchronous, `rst_n` low):**
  - All `regs` = 0.
  - All busy bits = 0.
  - `rs1_data` and `rs2_data` follow the reset contents, so they read 0 unless bypassed.
  - `stall` = 0.
  - Reset mid-operation discards all pending busy state immediately.
- **Read latency:** 0 cycles (combinational).
- **Write latency:** the written value is visible through `regs` on the cycle after the write. It is visible through the bypass on the same cycle.
- **`stall`:** combinational from the inputs and current busy state. There is no registered path.
- **Busy lifetime:** a busy bit set by an accept at edge N is observable from cycle N+1. It clears at the edge where a matching `wr_en` occurs.
- **Back-to-back dependency:** a producer accepted at cycle N and a dependent instruction presented at N+1 stall until the producer's write-back cycle. The dependent is accepted in the write-back cycle itself, using the bypass.

## Structure
- **Shared constants** go in the common define file:
  - `XLEN`
  - `REG_AW`
  - `REG_X0` index (0)
- **Sub-module `reg_scoreboard`** holds:
  - the busy vector
  - set/clear logic
  - `stall` generation
- **Top (`reg_file_sb`)** holds:
  - the register array
  - the bypass muxes
  - the x0 masking

## Test plan
- **Reset:** assert `rst_n` = 0 mid-run with `busy_vec` nonzero -> `busy_vec` = 0 and `stall` = 0 immediately; all reads return 0 after release.
- **Write then read:** write `x5` = 0xDEADBEEF with `rs1_addr` = 5 in the same cycle -> `rs1_data` = 0xDEADBEEF via bypass; the next cycle reads the same from the array. A write to `x0` of 0x1234 reads back 0.
- **RAW stall:**
  - Accept `issue_rd` = 7 with `issue_wr` = 1.
  - Next cycle, present `rs2_used` = 1 with `rs2_addr` = 7 -> `stall` = 1 for 3 cycles.
  - Then `wr_en`, `wr_rd` = 7, `wr_data` = 0x55 -> `stall` = 0, `rs2_data` = 0x55, accept.
- **WAW:** `x9` busy, new instruction with `issue_rd` = 9 -> `stall` = 1 until `x9` writes back. In that cycle `accept` = 1 and `busy[9]` remains 1 (set wins over clear).
- **Unused operand:** `x3` busy, instruction with `rs1_addr` = 3 and `rs1_used` = 0 -> `stall` = 0.
- **Dual source:** `x4` and `x6` both busy, instruction reads both -> stall persists until both have written back in any order; `stall` drops in the cycle of the last write-back.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the register file / scoreboard slice.
//   XLEN   : data width
//   REG_AW : register index width (2^REG_AW registers)
//   REG_X0 : index of the hard-wired zero register
package reg_file_sb_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned REG_X0 = 0;
endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/issue and write-back bus of the register file.
//   write-back : wr_en, wr_rd, wr_data
//   read ports : rs1_addr/rs1_data, rs2_addr/rs2_data
//   issue      : issue_valid, rs1_used, rs2_used, issue_wr, issue_rd, stall
//   debug      : busy_vec (one bit per register)
// slave  = register file side, master = pipeline side.
interface reg_file_sb_if #(
  parameter int unsigned XLEN = reg_file_sb_pkg::XLEN,
  parameter int unsigned AW   = reg_file_sb_pkg::REG_AW
);
  localparam int unsigned NREGS = 1 << AW;

  logic            wr_en;
  logic [AW-1:0]   wr_rd;
  logic [XLEN-1:0] wr_data;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            issue_valid;
  logic            rs1_used;
  logic            rs2_used;
  logic            issue_wr;
  logic [AW-1:0]   issue_rd;
  logic            stall;
  logic [NREGS-1:0] busy_vec;

  modport slave (
    input  wr_en, wr_rd, wr_data, rs1_addr, rs2_addr,
           issue_valid, rs1_used, rs2_used, issue_wr, issue_rd,
    output rs1_data, rs2_data, stall, busy_vec
  );

  modport master (
    output wr_en, wr_rd, wr_data, rs1_addr, rs2_addr,
           issue_valid, rs1_used, rs2_used, issue_wr, issue_rd,
    input  rs1_data, rs2_data, stall, busy_vec
  );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Busy-bit scoreboard: one bit per register marking an in-flight producer.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   wr_en, wr_rd          : write-back in progress (clears busy)
//   issue_valid, rs*_used, rs*_addr, issue_wr, issue_rd : issuing instruction
//   stall                 : combinational hazard indication
//   busy_vec              : current busy bits
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned AW = reg_file_sb_pkg::REG_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_rd,
  input  logic               issue_valid,
  input  logic               rs1_used,
  input  logic [AW-1:0]      rs1_addr,
  input  logic               rs2_used,
  input  logic [AW-1:0]      rs2_addr,
  input  logic               issue_wr,
  input  logic [AW-1:0]      issue_rd,
  output logic               stall,
  output logic [(1<<AW)-1:0] busy_vec
);
  localparam int unsigned NREGS = 1 << AW;

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] eff_busy;
  logic             accept;

  // A register being written back this cycle is not a hazard: the read
  // bypass in the top supplies its data.
  always_comb begin
    clr_vec = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      clr_vec[i] = wr_en && (wr_rd == AW'(i));
    end
    eff_busy = busy & ~clr_vec;
  end

  always_comb begin
    stall = issue_valid && ((rs1_used && eff_busy[rs1_addr]) ||
                            (rs2_used && eff_busy[rs2_addr]) ||
                            (issue_wr && eff_busy[issue_rd]));
    accept = issue_valid && !stall;
  end

  always_comb begin
    set_vec = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      set_vec[i] = accept && issue_wr && (issue_rd == AW'(i)) && (i != REG_X0);
    end
  end

  // Set has priority: a newly accepted producer owns the register even if
  // the previous producer writes back on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (set_vec[i]) begin
          busy[i] <= 1'b1;
        end else if (clr_vec[i]) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  assign busy_vec = busy;
endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with write-back port, two combinational read ports
// with write-through bypass, and a busy-bit scoreboard for RAW/WAW hazards.
// Ports:
//   clk   : system clock
//   rst_n : async active-low reset (clears registers and busy bits)
//   bus   : reg_file_sb_if.slave (write-back, read, issue, stall, busy_vec)
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned XLEN = reg_file_sb_pkg::XLEN,
  parameter int unsigned AW   = reg_file_sb_pkg::REG_AW
) (
  input logic           clk,
  input logic           rst_n,
  reg_file_sb_if.slave  bus
);
  localparam int unsigned NREGS = 1 << AW;
  localparam logic [AW-1:0] X0 = AW'(REG_X0);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wr_en && (bus.wr_rd != X0)) begin
      regs[bus.wr_rd] <= bus.wr_data;
    end
  end

  always_comb begin
    if (bus.rs1_addr == X0) begin
      bus.rs1_data = '0;
    end else if (bus.wr_en && (bus.wr_rd == bus.rs1_addr)) begin
      bus.rs1_data = bus.wr_data;
    end else begin
      bus.rs1_data = regs[bus.rs1_addr];
    end
  end

  always_comb begin
    if (bus.rs2_addr == X0) begin
      bus.rs2_data = '0;
    end else if (bus.wr_en && (bus.wr_rd == bus.rs2_addr)) begin
      bus.rs2_data = bus.wr_data;
    end else begin
      bus.rs2_data = regs[bus.rs2_addr];
    end
  end

  reg_scoreboard #(
    .AW(AW)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (bus.wr_en),
    .wr_rd      (bus.wr_rd),
    .issue_valid(bus.issue_valid),
    .rs1_used   (bus.rs1_used),
    .rs1_addr   (bus.rs1_addr),
    .rs2_used   (bus.rs2_used),
    .rs2_addr   (bus.rs2_addr),
    .issue_wr   (bus.issue_wr),
    .issue_rd   (bus.issue_rd),
    .stall      (bus.stall),
    .busy_vec   (bus.busy_vec)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  logic clk;
  logic rst_n;

  reg_file_sb_if #(.XLEN(32), .AW(5)) bus ();

  reg_file_sb #(.XLEN(32), .AW(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  logic [31:0] exp_q [$];
  logic [31:0] e;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.wr_rd = '0; bus.wr_data = '0;
    bus.rs1_addr = '0; bus.rs2_addr = '0;
    bus.issue_valid = 1'b0; bus.rs1_used = 1'b0; bus.rs2_used = 1'b0;
    bus.issue_wr = 1'b0; bus.issue_rd = '0;
  endtask

  // Inputs change on the falling edge; comb outputs are sampled 1 ns later.
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    bus.issue_valid = 1'b1; bus.rs1_used = 1'b1; bus.rs1_addr = 5'd3;
    bus.issue_wr = 1'b1; bus.issue_rd = 5'd3;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    checks++; e = exp_q.pop_front();
    if ({31'b0, bus.stall} !== e) begin failures++; $display("FAIL reset_stall got=%0h exp=%0h", bus.stall, e); end
    checks++; e = exp_q.pop_front();
    if (bus.busy_vec !== e) begin failures++; $display("FAIL reset_busy got=%0h exp=%0h", bus.busy_vec, e); end
    checks++; e = exp_q.pop_front();
    if (bus.rs1_data !== e) begin failures++; $display("FAIL reset_rs1 got=%0h exp=%0h", bus.rs1_data, e); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_rd = 5'd5; bus.wr_data = 32'hDEADBEEF;
    bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd6;
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'h0);
    #1;
    checks++; e = exp_q.pop_front();
    if (bus.rs1_data !== e) begin failures++; $display("FAIL bypass_rs1 got=%0h exp=%0h", bus.rs1_data, e); end
    checks++; e = exp_q.pop_front();
    if (bus.rs2_data !== e) begin failures++; $display("FAIL bypass_other got=%0h exp=%0h", bus.rs2_data, e); end
    @(negedge clk);
    bus.wr_en = 1'b0; bus.wr_data = 32'h0; bus.rs2_addr = 5'd5;
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF);
    #1;
    checks++; e = exp_q.pop_front();
    if (bus.rs1_data !== e) begin failures++; $display("FAIL array_rs1 got=%0h exp=%0h", bus.rs1_data, e); end
    checks++; e = exp_q.pop_front();
    if (bus.rs2_data !== e) begin failures++; $display("FAIL array_rs2 got=%0h exp=%0h", bus.rs2_data, e); end
    // x0 write is dropped, both in the bypass and in the array
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_rd = 5'd0; bus.wr_data = 32'h1234;
    bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0;
    exp_q.push_back(32'h0);
    #1;
    checks++; e = exp_q.pop_front();
    if (bus.rs1_data !== e) begin failures++; $display("FAIL x0_bypass got=%0h exp=%0h", bus.rs1_data, e); end
    @(negedge clk);
    bus.wr_en = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'hDEADBEEF);
    #1;
    checks++; e = exp_q.pop_front();
    if (bus.rs2_data !== e) begin failures++; $display("FAIL x0_array got=%0h exp=%0h", bus.rs2_data, e); end
    bus.rs1_addr = 5'd5;
    #1;
    checks++; e = exp_q.pop_front();
    if (bus.rs1_data !== e) begin failures++; $display("FAIL x5_kept got=%0h exp=%0h", bus.rs1_data, e); end
    idle_inputs();
  endtask

  task automatic test_raw();
    @(negedge clk);
    bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd7;
    exp_q.push_back(32'h0);
    #1;
    checks++; e = exp_q.pop_front();
    if ({31'b0, bus.stall} !== e) begin failures++; $display("FAIL raw_producer_stall got=%0h exp=%0h", bus.stall, e); end
    @(negedge clk);
    bus.issue_wr = 1'b0; bus.issue_rd = '0; bus.rs2_used = 1'b1; bus.rs2_addr = 5'd7;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      exp_q.push_back(32'h1); exp_q.push_back(32'h0000_0080);
      #1;
      checks++; e = exp_q.pop_front();
      if ({31'b0, bus.stall} !== e) begin failures++; $display("FAIL raw_stall[%0d] got=%0h exp=%0h", i, bus.stall, e); end
      checks++; e = exp_q.pop_front();
      if (bus.busy_vec !== e) begin failures++; $display("FAIL raw_busy[%0d] got=%0h exp=%0h", i, bus.busy_vec, e); end
    end
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_rd = 5'd7; bus.wr_data = 32'h55;
    exp_q.push_back(32'h0); exp_q.push_back(32'h55);
    #1;
    checks++; e = exp_q.pop_front();
    if ({31'b0, bus.stall} !== e) begin failures++; $display("FAIL raw_release got=%0h exp=%0h", bus.stall, e); end
    checks++; e = exp_q.pop_front();
    if (bus.rs2_data !== e) begin failures++; $display("FAIL raw_bypass got=%0h exp=%0h", bus.rs2_data, e); end
    @(negedge clk);
    idle_inputs();
    exp_q.push_back(32'h0);
    #1;
    checks++; e = exp_q.pop_front();
    if (bus.busy_vec !== e) begin failures++; $display("FAIL raw_busy_cleared got=%0h exp=%0h", bus.busy_vec, e); end
  endtask

  task automatic test_waw();
    @(negedge clk);
    bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd9;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      exp_q.push_back(32'h1);
      #1;
      checks++; e = exp_q.pop_front();
      if ({31'b0, bus.stall} !== e) begin failures++; $display("FAIL waw_stall[%0d] got=%0h exp=%0h", i, bus.stall, e); end
    end
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_rd = 5'd9; bus.wr_data = 32'h99;
    exp_q.push_back(32'h0);
    #1;
    checks++; e = exp_q.pop_front();
    if ({31'b0, bus.stall} !== e) begin failures++; $display("FAIL waw_accept got=%0h exp=%0h", bus.stall, e); end
    @(negedge clk);
    idle_inputs();
    exp_q.push_back(32'h0000_0200);
    #1;
    checks++; e = exp_q.pop_front();
    if (bus.busy_vec !== e) begin failures++; $display("FAIL waw_set_wins got=%0h exp=%0h", bus.busy_vec, e); end
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_rd = 5'd9; bus.wr_data = 32'h9A;
    @(negedge clk);
    idle_inputs();
    exp_q.push_back(32'h0);
    #1;
    checks++; e = exp_q.pop_front();
    if (bus.busy_vec !== e) begin failures++; $display("FAIL waw_cleared got=%0h exp=%0h", bus.busy_vec, e); end
  endtask

  task automatic test_unused();
    @(negedge clk);
    bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd3;
    @(negedge clk);
    bus.issue_wr = 1'b0; bus.issue_rd = '0; bus.rs1_addr = 5'd3; bus.rs1_used = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    #1;
    checks++; e = exp_q.pop_front();
    if ({31'b0, bus.stall} !== e) begin failures++; $display("FAIL unused_no_stall got=%0h exp=%0h", bus.stall, e); end
    bus.rs1_used = 1'b1;
    #1;
    checks++; e = exp_q.pop_front();
    if ({31'b0, bus.stall} !== e) begin failures++; $display("FAIL used_stall got=%0h exp=%0h", bus.stall, e); end
    bus.issue_valid = 1'b0; bus.rs1_used = 1'b0;
    bus.wr_en = 1'b1; bus.wr_rd = 5'd3; bus.wr_data = 32'h33;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_dual();
    @(negedge clk);
    bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd4;
    @(negedge clk);
    bus.issue_rd = 5'd6;
    @(negedge clk);
    bus.issue_wr = 1'b0; bus.issue_rd = '0;
    bus.rs1_used = 1'b1; bus.rs1_addr = 5'd4; bus.rs2_used = 1'b1; bus.rs2_addr = 5'd6;
    exp_q.push_back(32'h1); exp_q.push_back(32'h0000_0050);
    #1;
    checks++; e = exp_q.pop_front();
    if ({31'b0, bus.stall} !== e) begin failures++; $display("FAIL dual_stall got=%0h exp=%0h", bus.stall, e); end
    checks++; e = exp_q.pop_front();
    if (bus.busy_vec !== e) begin failures++; $display("FAIL dual_busy got=%0h exp=%0h", bus.busy_vec, e); end
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_rd = 5'd6; bus.wr_data = 32'h66;
    exp_q.push_back(32'h1);
    #1;
    checks++; e = exp_q.pop_front();
    if ({31'b0, bus.stall} !== e) begin failures++; $display("FAIL dual_first_wb got=%0h exp=%0h", bus.stall, e); end
    @(negedge clk);
    bus.wr_rd = 5'd4; bus.wr_data = 32'h44;
    exp_q.push_back(32'h0); exp_q.push_back(32'h44); exp_q.push_back(32'h66);
    #1;
    checks++; e = exp_q.pop_front();
    if ({31'b0, bus.stall} !== e) begin failures++; $display("FAIL dual_last_wb got=%0h exp=%0h", bus.stall, e); end
    checks++; e = exp_q.pop_front();
    if (bus.rs1_data !== e) begin failures++; $display("FAIL dual_rs1 got=%0h exp=%0h", bus.rs1_data, e); end
    checks++; e = exp_q.pop_front();
    if (bus.rs2_data !== e) begin failures++; $display("FAIL dual_rs2 got=%0h exp=%0h", bus.rs2_data, e); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_midrun_reset();
    @(negedge clk);
    bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd10;
    @(negedge clk);
    bus.issue_wr = 1'b0; bus.issue_rd = '0; bus.rs1_used = 1'b1; bus.rs1_addr = 5'd10;
    exp_q.push_back(32'h0000_0400); exp_q.push_back(32'h1);
    #1;
    checks++; e = exp_q.pop_front();
    if (bus.busy_vec !== e) begin failures++; $display("FAIL pre_reset_busy got=%0h exp=%0h", bus.busy_vec, e); end
    checks++; e = exp_q.pop_front();
    if ({31'b0, bus.stall} !== e) begin failures++; $display("FAIL pre_reset_stall got=%0h exp=%0h", bus.stall, e); end
    #1;
    rst_n = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    checks++; e = exp_q.pop_front();
    if (bus.busy_vec !== e) begin failures++; $display("FAIL async_reset_busy got=%0h exp=%0h", bus.busy_vec, e); end
    checks++; e = exp_q.pop_front();
    if ({31'b0, bus.stall} !== e) begin failures++; $display("FAIL async_reset_stall got=%0h exp=%0h", bus.stall, e); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd7;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    checks++; e = exp_q.pop_front();
    if (bus.rs1_data !== e) begin failures++; $display("FAIL post_reset_x5 got=%0h exp=%0h", bus.rs1_data, e); end
    checks++; e = exp_q.pop_front();
    if (bus.rs2_data !== e) begin failures++; $display("FAIL post_reset_x7 got=%0h exp=%0h", bus.rs2_data, e); end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_write_read();
    test_raw();
    test_waw();
    test_unused();
    test_dual();
    test_midrun_reset();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
